led_word_viewer: RTL and testbench

Debug display block for the PIC24 programmer top level. It keeps the last DEPTH data words of width DATA_W in a circular history buffer and shows one LED_W-bit lane of one stored word on the board LEDs. A single debounced push-button selects what is shown: a short press steps the byte lane, and a long press steps back through the history. It replaces the fixed 16-bit/2-lane LED register and toggle logic in the top level.

---
 rtl/led_viewer_pkg.sv | 43 ++++
 rtl/button_press_detector.sv | 97 +++++++++
 rtl/led_word_viewer.sv | 97 +++++++++
 tb/tb_led_word_viewer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_viewer_pkg.sv
// Shared helpers for the LED word viewer: width derivation and press FSM encoding.
package led_viewer_pkg;

  typedef enum logic [1:0] {
    PRESS_IDLE      = 2'd0,
    PRESS_PRESSED   = 2'd1,
    PRESS_LONG_HELD = 2'd2
  } press_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned result;
    v = (value > 0) ? value - 1 : 0;
    result = 0;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int unsigned max1(input int unsigned value);
    return (value < 1) ? 1 : value;
  endfunction

  function automatic int unsigned lanes_of(input int unsigned data_w, input int unsigned led_w);
    return (data_w + led_w - 1) / led_w;
  endfunction

  function automatic int unsigned lane_w_of(input int unsigned data_w, input int unsigned led_w);
    return max1(clog2(lanes_of(data_w, led_w)));
  endfunction

  function automatic int unsigned entry_w_of(input int unsigned depth);
    return max1(clog2(depth));
  endfunction

  // Bits needed to hold the value max_value itself.
  function automatic int unsigned count_w_of(input int unsigned max_value);
    return max1(clog2(max_value + 1));
  endfunction

endpackage

// File: rtl/button_press_detector.sv
// Synchronises and debounces the raw button, then classifies each press as short or long.
module button_press_detector
  import led_viewer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned LONG_PRESS_CYCLES = 25000000
) (
  input  logic clk50MHz,
  input  logic reset,
  input  logic button,
  output logic short_evt,
  output logic long_evt
);

  localparam int unsigned DW = count_w_of(DEBOUNCE_CYCLES);
  localparam int unsigned HW = count_w_of(LONG_PRESS_CYCLES);

  localparam logic [1:0] IDLE      = 2'(PRESS_IDLE);
  localparam logic [1:0] PRESSED   = 2'(PRESS_PRESSED);
  localparam logic [1:0] LONG_HELD = 2'(PRESS_LONG_HELD);

  logic [1:0]    sync_q;
  logic          btn_sync;
  logic          btn_db;
  logic [DW-1:0] db_cnt;
  logic [1:0]    state_q, state_d;
  logic [HW-1:0] hc_q, hc_d;
  logic          short_d, long_d;

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], button};
  end

  assign btn_sync = sync_q[1];

  // Accept a new level only after it has differed from btn_db for DEBOUNCE_CYCLES straight cycles.
  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_sync == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt >= DW'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= btn_sync;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      hc_q      <= '0;
      short_evt <= 1'b0;
      long_evt  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hc_q      <= hc_d;
      short_evt <= short_d;
      long_evt  <= long_d;
    end
  end

  // Long classification wins over a release seen in the same cycle.
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_db) begin
          state_d = PRESSED;
          hc_d    = '0;
        end
      end
      PRESSED: begin
        if (hc_q >= HW'(LONG_PRESS_CYCLES - 1)) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end else if (!btn_db) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else begin
          hc_d = hc_q + HW'(1);
        end
      end
      LONG_HELD: begin
        if (!btn_db) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/led_word_viewer.sv
// Keeps a short history of captured words and shows one selected byte lane on the LEDs.
module led_word_viewer
  import led_viewer_pkg::*;
#(
  parameter  int unsigned DATA_W            = 16,
  parameter  int unsigned LED_W             = 8,
  parameter  int unsigned DEPTH             = 4,
  parameter  int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter  int unsigned LONG_PRESS_CYCLES = 25000000,
  parameter  int unsigned FLASH_CYCLES      = 5000000,
  localparam int unsigned LW                = lane_w_of(DATA_W, LED_W),
  localparam int unsigned EW                = entry_w_of(DEPTH)
) (
  input  logic              clk50MHz,
  input  logic              reset,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              button,
  output logic [LED_W-1:0]  leds,
  output logic [LW-1:0]     sel_lane,
  output logic [EW-1:0]     sel_entry,
  output logic              new_flag
);

  localparam int unsigned LANES = lanes_of(DATA_W, LED_W);
  localparam int unsigned PAD_W = LANES * LED_W;
  localparam int unsigned IW    = EW + 2;
  localparam int unsigned FW    = count_w_of(FLASH_CYCLES);

  logic              short_evt, long_evt;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [EW-1:0]     wr_ptr;
  logic [FW-1:0]     flash_cnt;
  logic [IW-1:0]     rd_sum_c;
  logic [EW-1:0]     rd_idx_c;
  logic [PAD_W-1:0]  word_c;
  logic [LED_W-1:0]  leds_c;

  button_press_detector #(
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) u_button_press_detector (
    .clk50MHz (clk50MHz),
    .reset    (reset),
    .button   (button),
    .short_evt(short_evt),
    .long_evt (long_evt)
  );

  // Circular history; the oldest entry is silently overwritten.
  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr <= '0;
    end else if (din_valid) begin
      mem_q[wr_ptr] <= din;
      wr_ptr        <= (wr_ptr == EW'(DEPTH - 1)) ? '0 : wr_ptr + EW'(1);
    end
  end

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      sel_lane  <= '0;
      sel_entry <= '0;
    end else if (long_evt) begin
      sel_lane  <= '0;
      sel_entry <= (sel_entry == EW'(DEPTH - 1)) ? '0 : sel_entry + EW'(1);
    end else if (short_evt) begin
      sel_lane  <= (sel_lane == LW'(LANES - 1)) ? '0 : sel_lane + LW'(1);
    end
  end

  // Index relative to the newest word, wrapped by compare-and-subtract so any DEPTH works.
  always_comb begin
    rd_sum_c = IW'(wr_ptr) + IW'(DEPTH) - IW'(1) - IW'(sel_entry);
    rd_idx_c = (rd_sum_c >= IW'(DEPTH)) ? EW'(rd_sum_c - IW'(DEPTH)) : EW'(rd_sum_c);
    word_c   = PAD_W'(mem_q[rd_idx_c]);
    leds_c   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (sel_lane == LW'(l)) leds_c = word_c[l*LED_W +: LED_W];
    end
  end

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      leds      <= '0;
      flash_cnt <= '0;
      new_flag  <= 1'b0;
    end else begin
      leds <= leds_c;
      if (din_valid)             flash_cnt <= FW'(FLASH_CYCLES);
      else if (flash_cnt != '0)  flash_cnt <= flash_cnt - FW'(1);
      new_flag <= din_valid ? (FLASH_CYCLES != 0) : (flash_cnt > FW'(1));
    end
  end

endmodule

// File: tb/tb_led_word_viewer.sv
// Self-checking bench for led_word_viewer against a history/selection reference model.
module tb_led_word_viewer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DEB    = 4;
  localparam int unsigned LONG   = 20;
  localparam int unsigned FLASH  = 10;
  localparam int unsigned LANES  = 2;
  localparam int          SETTLE = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              button;
  logic [LED_W-1:0]  leds;
  logic [0:0]        sel_lane;
  logic [1:0]        sel_entry;
  logic              new_flag;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] hist [DEPTH];
  int m_lane;
  int m_entry;

  led_word_viewer #(
    .DATA_W(DATA_W), .LED_W(LED_W), .DEPTH(DEPTH),
    .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .FLASH_CYCLES(FLASH)
  ) dut (
    .clk50MHz (clk),
    .reset    (reset),
    .din_valid(din_valid),
    .din      (din),
    .button   (button),
    .leds     (leds),
    .sel_lane (sel_lane),
    .sel_entry(sel_entry),
    .new_flag (new_flag)
  );

  always #10 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: hist[0] is the newest word, unwritten slots are zero.
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) hist[i] = '0;
    m_lane  = 0;
    m_entry = 0;
  endtask

  task automatic model_capture(input logic [DATA_W-1:0] w);
    for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = w;
  endtask

  // A raw hold of h cycles is filtered if shorter than DEB, long if at least LONG.
  task automatic model_press(input int h);
    if (h >= LONG) begin
      m_entry = (m_entry + 1) % DEPTH;
      m_lane  = 0;
    end else if (h >= DEB) begin
      m_lane = (m_lane + 1) % LANES;
    end
  endtask

  function automatic logic [LED_W-1:0] exp_leds();
    logic [DATA_W-1:0] w;
    w = hist[m_entry];
    return LED_W'(w >> (LED_W * m_lane));
  endfunction

  task automatic do_press(input int h, input bit rnd);
    button = 1'b1;
    for (int i = 0; i < h; i++) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        din       = DATA_W'($urandom);
        din_valid = 1'b1;
        model_capture(din);
      end else begin
        din_valid = 1'b0;
      end
      tick();
    end
    din_valid = 1'b0;
    button    = 1'b0;
    repeat (SETTLE) tick();
    model_press(h);
  endtask

  task automatic do_capture(input logic [DATA_W-1:0] w);
    din       = w;
    din_valid = 1'b1;
    model_capture(w);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; din_valid = 1'b0; din = '0; button = 1'b0;
    model_reset();
    repeat (3) tick();
    checks++; if (leds !== 8'h00)     begin errors++; $display("FAIL reset_leds got %h expected 00", leds); end
    checks++; if (sel_lane !== 1'b0)  begin errors++; $display("FAIL reset_lane got %0d expected 0", sel_lane); end
    checks++; if (sel_entry !== 2'd0) begin errors++; $display("FAIL reset_entry got %0d expected 0", sel_entry); end
    checks++; if (new_flag !== 1'b0)  begin errors++; $display("FAIL reset_flag got %b expected 0", new_flag); end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_capture();
    int high;
    do_capture(16'hA55A);
    checks++; if (leds !== 8'h00) begin errors++; $display("FAIL cap_latency got %h expected 00", leds); end
    high = new_flag ? 1 : 0;
    tick();
    checks++; if (leds !== 8'h5A) begin errors++; $display("FAIL cap_leds got %h expected 5a", leds); end
    if (new_flag) high++;
    repeat (12) begin
      tick();
      if (new_flag) high++;
    end
    checks++; if (high != FLASH) begin errors++; $display("FAIL flash_len got %0d expected %0d", high, FLASH); end
    checks++; if (new_flag !== 1'b0) begin errors++; $display("FAIL flash_end got %b expected 0", new_flag); end
  endtask

  task automatic test_short_press();
    do_press(8, 1'b0);
    checks++; if (sel_lane !== 1'b1) begin errors++; $display("FAIL short1_lane got %0d expected 1", sel_lane); end
    checks++; if (leds !== 8'hA5)    begin errors++; $display("FAIL short1_leds got %h expected a5", leds); end
    do_press(8, 1'b0);
    checks++; if (sel_lane !== 1'b0) begin errors++; $display("FAIL short2_lane got %0d expected 0", sel_lane); end
    checks++; if (leds !== 8'h5A)    begin errors++; $display("FAIL short2_leds got %h expected 5a", leds); end
  endtask

  task automatic test_glitch();
    do_press(3, 1'b0);
    checks++; if (sel_lane !== 1'b0)  begin errors++; $display("FAIL glitch_lane got %0d expected 0", sel_lane); end
    checks++; if (sel_entry !== 2'd0) begin errors++; $display("FAIL glitch_entry got %0d expected 0", sel_entry); end
    checks++; if (leds !== 8'h5A)     begin errors++; $display("FAIL glitch_leds got %h expected 5a", leds); end
  endtask

  task automatic test_long_press();
    logic [7:0] exp_l [4] = '{8'h44, 8'h33, 8'h22, 8'h55};
    logic [1:0] exp_e [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    din_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      din = DATA_W'(16'h1111 * i);
      model_capture(din);
      tick();
    end
    din_valid = 1'b0;
    repeat (3) tick();
    checks++; if (leds !== 8'h55) begin errors++; $display("FAIL b2b_leds got %h expected 55", leds); end
    for (int i = 0; i < 4; i++) begin
      do_press(30, 1'b0);
      checks++; if (sel_entry !== exp_e[i]) begin errors++; $display("FAIL long%0d_entry got %0d expected %0d", i, sel_entry, exp_e[i]); end
      checks++; if (sel_lane !== 1'b0)      begin errors++; $display("FAIL long%0d_lane got %0d expected 0", i, sel_lane); end
      checks++; if (leds !== exp_l[i])      begin errors++; $display("FAIL long%0d_leds got %h expected %h", i, leds, exp_l[i]); end
    end
  endtask

  // Button held 8 cycles: btn_db falls 8+2+DEB cycles on, short_evt one cycle after the FSM sees it.
  task automatic test_simultaneous();
    button = 1'b1;
    repeat (8) tick();
    button = 1'b0;
    repeat (7) tick();
    din       = 16'h6666;
    din_valid = 1'b1;
    model_capture(16'h6666);
    model_press(8);
    tick();
    din_valid = 1'b0;
    checks++; if (sel_lane !== 1'b1) begin errors++; $display("FAIL simul_lane got %0d expected 1", sel_lane); end
    tick();
    checks++; if (leds !== 8'h66) begin errors++; $display("FAIL simul_leds got %h expected 66", leds); end
    repeat (SETTLE) tick();
  endtask

  task automatic test_press_boundary();
    do_press(LONG - 1, 1'b0);
    checks++; if (sel_lane !== 1'(m_lane))   begin errors++; $display("FAIL bound19_lane got %0d expected %0d", sel_lane, m_lane); end
    checks++; if (sel_entry !== 2'(m_entry)) begin errors++; $display("FAIL bound19_entry got %0d expected %0d", sel_entry, m_entry); end
    do_press(LONG, 1'b0);
    checks++; if (sel_entry !== 2'(m_entry)) begin errors++; $display("FAIL bound20_entry got %0d expected %0d", sel_entry, m_entry); end
    checks++; if (sel_lane !== 1'(m_lane))   begin errors++; $display("FAIL bound20_lane got %0d expected %0d", sel_lane, m_lane); end
    checks++; if (leds !== exp_leds())       begin errors++; $display("FAIL bound20_leds got %h expected %h", leds, exp_leds()); end
  endtask

  task automatic test_random();
    int k;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          k = $urandom_range(1, 3);
          din_valid = 1'b1;
          for (int j = 0; j < k; j++) begin
            din = DATA_W'($urandom);
            model_capture(din);
            tick();
          end
          din_valid = 1'b0;
          repeat (3) tick();
          checks++; if (new_flag !== 1'b1) begin errors++; $display("FAIL rnd%0d_flag got %b expected 1", it, new_flag); end
        end
        1: do_press($urandom_range(DEB, LONG - 1), 1'b1);
        2: do_press($urandom_range(LONG, LONG + 15), 1'b1);
        default: do_press($urandom_range(1, DEB - 1), 1'b1);
      endcase
      checks++; if (leds !== exp_leds())       begin errors++; $display("FAIL rnd%0d_leds got %h expected %h", it, leds, exp_leds()); end
      checks++; if (sel_lane !== 1'(m_lane))   begin errors++; $display("FAIL rnd%0d_lane got %0d expected %0d", it, sel_lane, m_lane); end
      checks++; if (sel_entry !== 2'(m_entry)) begin errors++; $display("FAIL rnd%0d_entry got %0d expected %0d", it, sel_entry, m_entry); end
    end
  endtask

  task automatic test_reset_mid_press();
    do_capture(16'hBEEF);
    button = 1'b1;
    repeat (10) tick();
    reset = 1'b1;
    #2;
    model_reset();
    checks++; if (leds !== 8'h00)     begin errors++; $display("FAIL midrst_leds got %h expected 00", leds); end
    checks++; if (sel_lane !== 1'b0)  begin errors++; $display("FAIL midrst_lane got %0d expected 0", sel_lane); end
    checks++; if (sel_entry !== 2'd0) begin errors++; $display("FAIL midrst_entry got %0d expected 0", sel_entry); end
    checks++; if (new_flag !== 1'b0)  begin errors++; $display("FAIL midrst_flag got %b expected 0", new_flag); end
    repeat (2) tick();
    reset = 1'b0;
    repeat (15) tick();
    checks++; if (sel_lane !== 1'b0 || sel_entry !== 2'd0) begin
      errors++; $display("FAIL midrst_hold got lane %0d entry %0d expected 0 0", sel_lane, sel_entry);
    end
    button = 1'b0;
    repeat (SETTLE) tick();
    model_press(15);
    checks++; if (sel_lane !== 1'(m_lane)) begin errors++; $display("FAIL midrst_release_lane got %0d expected %0d", sel_lane, m_lane); end
    checks++; if (leds !== exp_leds())     begin errors++; $display("FAIL midrst_release_leds got %h expected %h", leds, exp_leds()); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_short_press();
    test_glitch();
    test_long_press();
    test_simultaneous();
    test_press_boundary();
    test_random();
    test_reset_mid_press();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
